// File: rtl/train_pkg.sv
// Shared definitions for the train controller: duration width,
// controller state encodings and the countdown timer FSM type.
package train_pkg;

   localparam int TIME_W = 19;

   localparam logic [3:0] CTRL_IDLE   = 4'b0000;
   localparam logic [3:0] CTRL_GREEN  = 4'b0011;
   localparam logic [3:0] CTRL_YELLOW = 4'b0100;

   typedef enum logic [1:0] {
      LOAD,
      RUN,
      DONE
   } timer_state_t;

endpackage

// File: rtl/train_timer_tick_gen.sv
// Prescaler for the train timer: emits one tick every PRESCALE
// enabled cycles, restarting from zero whenever clr is high.
module tick_gen #(
   parameter int PRESCALE = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] r_cnt;

   assign tick = en && (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= tick ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/train_timer.sv
// Countdown timer that reloads on every controller state change and
// pulses timeout on expiry. Optional freeze input: TRAIN_TIMER_HOLD_EN.
module train_timer
   import train_pkg::*;
#(
   parameter int WIDTH    = TIME_W,
   parameter int PRESCALE = 50000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       present_state,
   input  logic [WIDTH-1:0] tin,
`ifdef TRAIN_TIMER_HOLD_EN
   input  logic             hold,
`endif
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             timeout
);

   timer_state_t     r_state;
   timer_state_t     w_next;
   logic [3:0]       r_prev;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count_nxt;
   logic             r_timeout;
   logic             w_timeout_nxt;
   logic             w_chg;
   logic             w_tick;
   logic             w_hold;
   logic             w_en;
   logic             w_clr;

`ifdef TRAIN_TIMER_HOLD_EN
   assign w_hold = hold;
`else
   assign w_hold = 1'b0;
`endif

   assign w_chg = (present_state != r_prev);
   assign w_clr = (r_state == LOAD);
   assign w_en  = (r_state == RUN) && !w_hold;

   tick_gen #(
      .PRESCALE(PRESCALE)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (w_clr),
      .en   (w_en),
      .tick (w_tick)
   );

   // A state change always wins over expiry, so no stale timeout escapes.
   always_comb begin
      w_next        = r_state;
      w_count_nxt   = r_count;
      w_timeout_nxt = 1'b0;
      unique case (r_state)
         LOAD: begin
            w_count_nxt = tin;
            if (w_chg) begin
               w_next = LOAD;
            end else if (tin != '0) begin
               w_next = RUN;
            end else begin
               w_next        = DONE;
               w_timeout_nxt = 1'b1;
            end
         end
         RUN: begin
            if (w_chg) begin
               w_next = LOAD;
            end else if (w_tick) begin
               if (r_count <= WIDTH'(1)) begin
                  w_count_nxt   = '0;
                  w_next        = DONE;
                  w_timeout_nxt = 1'b1;
               end else begin
                  w_count_nxt = r_count - 1'b1;
               end
            end
         end
         DONE: begin
            w_count_nxt = '0;
            if (w_chg) begin
               w_next = LOAD;
            end
         end
         default: begin
            w_next = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= LOAD;
         r_prev    <= 4'b0000;
         r_count   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_prev    <= present_state;
         r_count   <= w_count_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign count   = r_count;
   assign timeout = r_timeout;
   assign busy    = (r_state == RUN);

endmodule

// File: tb/tb_train_timer.sv
// Randomised bench for train_timer with an elapsed-time reference model
// and a few hand-computed checkpoints.
module tb_train_timer;

   localparam int P = 4;
   localparam int W = 19;

   typedef struct {
      logic [3:0] prev;
      int         mode;
      int         t;
      int         el;
      int         cnt;
      bit         to;
   } mstate_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   ps = 4'h0;
   logic [W-1:0] tin = '0;
   logic         hold = 1'b0;
   logic [W-1:0] count;
   logic         busy;
   logic         timeout;

   int      n_vec = 0;
   int      n_err = 0;
   bit      chk_en = 1'b0;
   mstate_t m;

   always #5 clk = ~clk;

   train_timer #(
      .WIDTH(W),
      .PRESCALE(P)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .present_state(ps),
      .tin          (tin),
`ifdef TRAIN_TIMER_HOLD_EN
      .hold         (hold),
`endif
      .count        (count),
      .busy         (busy),
      .timeout      (timeout)
   );

   // mode: 0 = awaiting load, 1 = counting, 2 = expired.
   // Remaining units are derived from elapsed unheld run cycles.
   function automatic mstate_t step_model(mstate_t s, logic [3:0] p,
                                          int t, bit h);
      mstate_t n;
      bit      chg;
      n = s;
      chg = (p != s.prev);
      n.prev = p;
      n.to = 1'b0;
      case (s.mode)
         0: begin
            n.t = t;
            n.cnt = t;
            n.el = 0;
            if (!chg) begin
               if (t == 0) begin
                  n.mode = 2;
                  n.to = 1'b1;
               end else begin
                  n.mode = 1;
               end
            end
         end
         1: begin
            if (chg) begin
               n.mode = 0;
            end else if (!h) begin
               n.el = s.el + 1;
               if (n.el == s.t * P) begin
                  n.mode = 2;
                  n.cnt = 0;
                  n.to = 1'b1;
               end else begin
                  n.cnt = s.t - n.el / P;
               end
            end
         end
         default: begin
            if (chg) n.mode = 0;
         end
      endcase
      return n;
   endfunction

   function automatic mstate_t reset_model();
      mstate_t r;
      r.prev = 4'h0;
      r.mode = 0;
      r.t = 0;
      r.el = 0;
      r.cnt = 0;
      r.to = 1'b0;
      return r;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= reset_model();
      else m <= step_model(m, ps, int'(tin), hold);
   end

   task automatic check(string name, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_count", int'(count), m.cnt);
         check("model_busy", int'(busy), int'(m.mode == 1));
         check("model_timeout", int'(timeout), int'(m.to));
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      ps = 4'h0;
      tin = 19'd3;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      rst_n = 1'b1;

      for (int e = 1; e <= 14; e++) begin
         step();
         if (e == 1) begin
            check("rel_count_e1", int'(count), 3);
            check("rel_busy_e1", int'(busy), 1);
         end
         if (e == 5) check("rel_count_e5", int'(count), 2);
         if (e == 12) begin
            check("rel_count_e12", int'(count), 1);
            check("rel_to_e12", int'(timeout), 0);
         end
         if (e == 13) begin
            check("rel_count_e13", int'(count), 0);
            check("rel_to_e13", int'(timeout), 1);
            check("rel_busy_e13", int'(busy), 0);
         end
         if (e == 14) check("rel_to_e14", int'(timeout), 0);
      end

      ps = 4'b0011;
      tin = '0;
      step();
      check("zero_to_load", int'(timeout), 0);
      check("zero_busy_load", int'(busy), 0);
      step();
      check("zero_to_done", int'(timeout), 1);
      check("zero_busy_done", int'(busy), 0);
      step();
      check("zero_to_after", int'(timeout), 0);

      ps = 4'h4;
      tin = 19'd3;
      step();
      step();
      check("abort_start", int'(count), 3);
      k = 0;
      while (count != 2 && k < 20) begin
         step();
         k++;
      end
      check("abort_reach2", int'(count), 2);
      ps = 4'h5;
      tin = 19'd5;
      step();
      step();
      check("abort_reload", int'(count), 5);
      repeat (25) step();

      ps = 4'h6;
      tin = 19'd1;
      step();
      step();
      check("race_count1", int'(count), 1);
      repeat (3) step();
      ps = 4'h7;
      tin = 19'd9;
      step();
      check("race_no_to", int'(timeout), 0);
      check("race_busy", int'(busy), 0);
      step();
      check("race_reload", int'(count), 9);
      check("race_no_to2", int'(timeout), 0);

`ifdef TRAIN_TIMER_HOLD_EN
      ps = 4'h8;
      tin = 19'd2;
      step();
      step();
      step();
      hold = 1'b1;
      repeat (6) step();
      hold = 1'b0;
      check("hold_frozen", int'(count), 2);
      repeat (6) step();
      check("hold_to_early", int'(timeout), 0);
      step();
      check("hold_to_late", int'(timeout), 1);
`endif

      ps = 4'h9;
      tin = 19'd4;
      step();
      step();
      check("rst_pre_count", int'(count), 4);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_count", int'(count), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_to", int'(timeout), 0);
      @(negedge clk);
      ps = 4'h0;
      tin = 19'd6;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rst_reload", int'(count), 6);
      check("rst_reload_busy", int'(busy), 1);

      repeat (3000) begin
         if ($urandom_range(19) == 0) ps = 4'($urandom_range(15));
         if ($urandom_range(3) == 0) tin = W'($urandom_range(6));
`ifdef TRAIN_TIMER_HOLD_EN
         hold = ($urandom_range(4) == 0);
`endif
         rst_n = ($urandom_range(599) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
